adc_frame_packer: RTL and testbench

- Sits directly downstream of the ADC trigger/capture stage and consumes its valid-only 64-bit sample stream.
- Each contiguous tvalid burst becomes one frame of 64-bit words: a header word, packed data words carrying four 16-bit samples each, and a trailer word marked with tlast.
- Includes an output FIFO so a backpressured DMA writer can drain frames. The capture stage has no tready, so loss on backpressure is counted, never stalled.

---
 rtl/adc_frame_packer.sv | 199 +++++++++++++++++++
 tb/tb_adc_frame_packer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packer.sv
// ADC frame packer: turns valid-only sample bursts into header/data/trailer frames behind a FWFT output FIFO.
// Optional macro ADC_FRAME_PACKER_TRAILER_TS_EN puts ts[14:0] of the last frame sample into trailer bits [46:32].
module adc_frame_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          s_axis_tvalid,
    input  logic [63:0]                   s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [63:0]                   m_axis_tdata,
    output logic                          m_axis_tlast,
    input  logic                          clear_counters,
    output logic [CNT_WIDTH-1:0]          frame_count,
    output logic [CNT_WIDTH-1:0]          drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);
    // state   | meaning
    // IDLE    | waiting for the first sample of a burst
    // RUN     | packing samples into lanes
    // TRAIL   | writing the trailer word
    // DISCARD | ignoring the rest of a burst that could not be framed
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, TRAIL, DISCARD} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             lane_q, lane_d;
    logic [47:0]            data_q, data_d;
    logic [31:0]            scnt_q, scnt_d;
    logic                   dflag_q, dflag_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, drop_cnt_q;
    logic                   frame_inc, drop_inc;

    logic                   wr_en, wr_last;
    logic [63:0]            wr_data;
    logic [64:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]          level_q, level_d;
    logic                   pop, room;
    logic [14:0]            trail_ts;

    logic [15:0]            sample;
    logic [47:0]            ts;

    assign sample = s_axis_tdata[15:0];
    assign ts     = s_axis_tdata[63:16];
    assign room   = (level_q <= LW'(FIFO_DEPTH - 3));

`ifdef ADC_FRAME_PACKER_TRAILER_TS_EN
    logic [14:0] ts_last_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            ts_last_q <= '0;
        else if (s_axis_tvalid && (state_q == RUN || (state_q == IDLE && room)))
            ts_last_q <= s_axis_tdata[30:16];
    end
    assign trail_ts = ts_last_q;
`else
    assign trail_ts = 15'h0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_axis_tvalid) state_d = room ? RUN : DISCARD;
            RUN:     if (!s_axis_tvalid) state_d = TRAIL;
            TRAIL:   state_d = s_axis_tvalid ? DISCARD : IDLE;
            DISCARD: if (!s_axis_tvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_last   = 1'b0;
        wr_data   = 64'h0;
        lane_d    = lane_q;
        data_d    = data_q;
        scnt_d    = scnt_q;
        dflag_d   = dflag_q;
        frame_inc = 1'b0;
        drop_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    if (room) begin
                        wr_en     = 1'b1;
                        wr_data   = {16'hA5A5, ts};
                        lane_d    = 2'd1;
                        data_d    = {32'h0, sample};
                        scnt_d    = 32'd1;
                        dflag_d   = 1'b0;
                        frame_inc = 1'b1;
                    end else begin
                        drop_inc  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (s_axis_tvalid) begin
                    scnt_d = (scnt_q == 32'hFFFF_FFFF) ? scnt_q : scnt_q + 32'd1;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: data_d = {32'h0, sample};
                        2'd1: data_d[31:16] = sample;
                        2'd2: data_d[47:32] = sample;
                        default: begin
                            if (room) begin
                                wr_en   = 1'b1;
                                wr_data = {sample, data_q};
                            end else begin
                                drop_inc = 1'b1;
                                dflag_d  = 1'b1;
                            end
                        end
                    endcase
                end else if (lane_q != 2'd0) begin
                    // lanes above lane_q are already zero because lane 0 clears the word
                    wr_en   = 1'b1;
                    wr_data = {16'h0, data_q};
                end
            end
            TRAIL: begin
                wr_en    = 1'b1;
                wr_last  = 1'b1;
                wr_data  = {16'h5A5A, dflag_q, trail_ts, scnt_q};
                dflag_d  = 1'b0;
                lane_d   = 2'd0;
                drop_inc = s_axis_tvalid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lane_q  <= '0;
            data_q  <= '0;
            scnt_q  <= '0;
            dflag_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            data_q  <= data_d;
            scnt_q  <= scnt_d;
            dflag_q <= dflag_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (clear_counters) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (frame_inc && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (drop_inc && drop_cnt_q != '1)   drop_cnt_q  <= drop_cnt_q + 1'b1;
        end
    end

    // The room rule keeps writes from ever hitting a full FIFO, so push needs no guard.
    assign pop     = m_axis_tvalid && m_axis_tready;
    assign level_d = level_q + LW'(wr_en) - LW'(pop);

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr_q] <= {wr_last, wr_data};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    assign m_axis_tvalid = (level_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr_q][63:0] : 64'h0;
    assign m_axis_tlast  = m_axis_tvalid ? mem[rd_ptr_q][64] : 1'b0;
    assign fifo_level    = level_q;
    assign frame_count   = frame_cnt_q;
    assign drop_count    = drop_cnt_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer; expected frame words are hand-computed constants.
// Honours ADC_FRAME_PACKER_TRAILER_TS_EN for the trailer timestamp field.
module tb_adc_frame_packer;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_tvalid = 1'b0;
    logic [63:0]   s_tdata = 64'h0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [63:0]   m_tdata;
    logic          m_tlast;
    logic          clr = 1'b0;
    logic [CW-1:0] frame_count, drop_count;
    logic [4:0]    fifo_level;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [64:0] q[$];
    int max_level = 0;

    adc_frame_packer #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
        .clear_counters(clr), .frame_count(frame_count), .drop_count(drop_count),
        .fifo_level(fifo_level), .busy(busy)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) q.push_back({m_tlast, m_tdata});
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send(input int n, input logic [47:0] ts0, input logic [15:0] s0);
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {ts0 + 48'(i), s0 + 16'(i)};
            step(1);
        end
        s_tvalid = 1'b0;
    endtask

    function automatic logic [64:0] word(input int i);
        return (i < q.size()) ? q[i] : 65'h1_DEAD_BEEF_DEAD_BEEF;
    endfunction

    function automatic logic [63:0] trl(input logic [63:0] base, input logic [14:0] last_ts);
`ifdef ADC_FRAME_PACKER_TRAILER_TS_EN
        return base | {17'h0, last_ts, 32'h0};
`else
        return base | {64'(last_ts) & 64'h0};
`endif
    endfunction

    initial begin
        step(2);
        chk("rst_tvalid", 65'(m_tvalid), 65'd0);
        chk("rst_tlast", 65'(m_tlast), 65'd0);
        chk("rst_tdata", 65'(m_tdata), 65'd0);
        chk("rst_level", 65'(fifo_level), 65'd0);
        chk("rst_busy", 65'(busy), 65'd0);
        chk("rst_frames", 65'(frame_count), 65'd0);
        aresetn = 1'b1;
        m_tready = 1'b1;
        step(2);

        // 4-sample burst
        send(4, 48'd100, 16'h0001);
        step(8);
        chk("b4_words", 65'(q.size()), 65'd3);
        chk("b4_hdr", word(0), {1'b0, 64'hA5A5_0000_0000_0064});
        chk("b4_data", word(1), {1'b0, 64'h0004_0003_0002_0001});
        chk("b4_trl", word(2), {1'b1, trl(64'h5A5A_0000_0000_0004, 15'h0067)});
        chk("b4_frames", 65'(frame_count), 65'd1);
        chk("b4_busy", 65'(busy), 65'd0);
        q.delete();

        // 6-sample burst with partial word
        send(6, 48'd200, 16'h0011);
        step(8);
        chk("b6_words", 65'(q.size()), 65'd4);
        chk("b6_hdr", word(0), {1'b0, 64'hA5A5_0000_0000_00C8});
        chk("b6_data", word(1), {1'b0, 64'h0014_0013_0012_0011});
        chk("b6_part", word(2), {1'b0, 64'h0000_0000_0016_0015});
        chk("b6_trl", word(3), {1'b1, trl(64'h5A5A_0000_0000_0006, 15'h00CD)});
        q.delete();

        // 80 samples with the sink stalled
        m_tready = 1'b0;
        max_level = 0;
        send(80, 48'd1000, 16'h0000);
        step(5);
        chk("bp_level", 65'(fifo_level), 65'd15);
        chk("bp_max_ok", 65'(max_level <= DEPTH), 65'd1);
        chk("bp_drops", 65'(drop_count), 65'd7);
        chk("bp_frames", 65'(frame_count), 65'd3);
        m_tready = 1'b1;
        step(20);
        chk("bp_words", 65'(q.size()), 65'd15);
        chk("bp_hdr", word(0), {1'b0, 64'hA5A5_0000_0000_03E8});
        chk("bp_d1", word(1), {1'b0, 64'h0003_0002_0001_0000});
        chk("bp_last_data_tlast", 65'(word(13) >> 64), 65'd0);
        chk("bp_trl", word(14), {1'b1, trl(64'h5A5A_8000_0000_0050, 15'h0437)});
        chk("bp_empty", 65'(m_tvalid), 65'd0);
        q.delete();

        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_frames", 65'(frame_count), 65'd0);
        chk("clr_drops", 65'(drop_count), 65'd0);

        // second burst starts while the first frame's trailer is written
        send(3, 48'h10, 16'h0001);
        step(1);
        send(5, 48'h40, 16'h0100);
        step(8);
        chk("bb_words", 65'(q.size()), 65'd3);
        chk("bb_part", word(1), {1'b0, 64'h0000_0003_0002_0001});
        chk("bb_trl", word(2), {1'b1, trl(64'h5A5A_0000_0000_0003, 15'h0012)});
        chk("bb_drops", 65'(drop_count), 65'd1);
        chk("bb_frames", 65'(frame_count), 65'd1);
        q.delete();

        // reset in the middle of a burst, stalled sink so words sit in the FIFO
        m_tready = 1'b0;
        send(6, 48'h500, 16'h0033);
        s_tvalid = 1'b1;
        aresetn = 1'b0;
        #1;
        chk("mr_tvalid", 65'(m_tvalid), 65'd0);
        chk("mr_frames", 65'(frame_count), 65'd0);
        chk("mr_drops", 65'(drop_count), 65'd0);
        chk("mr_busy", 65'(busy), 65'd0);
        s_tvalid = 1'b0;
        step(2);
        aresetn = 1'b1;
        m_tready = 1'b1;
        step(2);
        q.delete();
        send(2, 48'h1_2344, 16'h0007);
        step(8);
        chk("mr_words", 65'(q.size()), 65'd3);
        chk("mr_hdr", word(0), {1'b0, 64'hA5A5_0000_0001_2344});
        chk("mr_part", word(1), {1'b0, 64'h0000_0000_0008_0007});
        chk("mr_trl", word(2), {1'b1, trl(64'h5A5A_0000_0000_0002, 15'h2345)});
        chk("mr_frames2", 65'(frame_count), 65'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
